sdm2_bitstream_gen: RTL



---
 rtl/sdm2_bitstream_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sdm2_bitstream_gen.sv
// Second-order sigma-delta modulator: signed frame-rate samples in, 1-bit stream out
// at the full clk rate, plus the frame-rate divided clock for the decimator.
// Optional LSB dither on the first integrator: define SDM2_DITHER_LFSR_EN.
module sdm2_bitstream_gen #(
    parameter int unsigned IN_WIDTH          = 16,
    parameter int unsigned DECIMATION_FACTOR = 256,
    parameter int unsigned ACC_WIDTH         = IN_WIDTH + 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [IN_WIDTH-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bit_out,
    output logic                frame_clk,
    output logic                underflow,
    input  logic                clear_underflow
);

    localparam int unsigned CNT_W = $clog2(DECIMATION_FACTOR);
    localparam int unsigned SUM_W = ACC_WIDTH + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION_FACTOR - 1);

    // Full scale and the integrator clamp limits, all at intermediate-sum width.
    localparam logic signed [SUM_W-1:0] FS_S =
        {{(SUM_W - IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH - 1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {3'b000, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {3'b111, {(ACC_WIDTH - 1){1'b0}}};

    // Clamp a wide sum back into the signed integrator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX) begin
            return SAT_MAX[ACC_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[ACC_WIDTH-1:0];
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        frame_clk_q;
    logic                        bit_q;
    logic                        underflow_q, underflow_d;
    logic                        ready_q;
    logic                        next_valid_q, next_valid_d;
    logic [IN_WIDTH-1:0]         next_q, next_d;
    logic signed [IN_WIDTH-1:0]  hold_q, hold_d;
    logic signed [ACC_WIDTH-1:0] i1_q, i1_d;
    logic signed [ACC_WIDTH-1:0] i2_q, i2_d;

    logic                        boundary;
    logic                        accept;
    logic                        y;
    logic signed [SUM_W-1:0]     x_s, fb_s, i1_s, i2_s, sum1_s, sum2_s;

`ifdef SDM2_DITHER_LFSR_EN
    logic [15:0]             lfsr_q;
    logic                    lfsr_fb;
    logic signed [SUM_W-1:0] dith_s;

    // Fibonacci LFSR, taps 16,14,13,11, advancing with the modulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign dith_s  = lfsr_q[0] ? SUM_W'(1) : {SUM_W{1'b1}};
`endif

    // Frame counter, pending-slot handshake, hold register and sticky underflow.
    always_comb begin
        cnt_d        = cnt_q;
        next_d       = next_q;
        next_valid_d = next_valid_q;
        hold_d       = hold_q;
        underflow_d  = underflow_q;

        boundary = enable && (cnt_q == CNT_LAST);
        accept   = sample_valid && ready_q;

        if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (boundary) begin
            if (next_valid_q) begin
                hold_d       = next_q;
                next_valid_d = 1'b0;
            end else if (accept) begin
                // Empty slot at the boundary: the arriving sample goes straight to hold.
                hold_d = sample_in;
            end
        end else if (accept) begin
            next_d       = sample_in;
            next_valid_d = 1'b1;
        end

        if (clear_underflow) begin
            underflow_d = 1'b0;
        end
        if (boundary && !next_valid_q && !accept) begin
            underflow_d = 1'b1;
        end
    end

    // Two integrators with +/-FS feedback from the sign of the second one.
    always_comb begin
        y    = ~i2_q[ACC_WIDTH-1];
        fb_s = y ? FS_S : -FS_S;
        x_s  = {{(SUM_W - IN_WIDTH){hold_q[IN_WIDTH-1]}}, hold_q};
        i1_s = {{2{i1_q[ACC_WIDTH-1]}}, i1_q};
        i2_s = {{2{i2_q[ACC_WIDTH-1]}}, i2_q};
`ifdef SDM2_DITHER_LFSR_EN
        sum1_s = i1_s + x_s - fb_s + dith_s;
`else
        sum1_s = i1_s + x_s - fb_s;
`endif
        sum2_s = i2_s + i1_s - fb_s;
        i1_d   = sat(sum1_s);
        i2_d   = sat(sum2_s);
    end

    // State registers; enable gates the counter, modulator and hold register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            frame_clk_q  <= 1'b0;
            bit_q        <= 1'b0;
            underflow_q  <= 1'b0;
            ready_q      <= 1'b1;
            next_valid_q <= 1'b0;
            next_q       <= '0;
            hold_q       <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
        end else begin
            next_q       <= next_d;
            next_valid_q <= next_valid_d;
            ready_q      <= ~next_valid_d;
            underflow_q  <= underflow_d;
            hold_q       <= hold_d;
            if (enable) begin
                cnt_q       <= cnt_d;
                frame_clk_q <= cnt_d[CNT_W-1];
                bit_q       <= y;
                i1_q        <= i1_d;
                i2_q        <= i2_d;
            end
        end
    end

    assign sample_ready = ready_q;
    assign bit_out      = bit_q;
    assign frame_clk    = frame_clk_q;
    assign underflow    = underflow_q;

endmodule
